// File: rtl/pb_port_arbiter.sv
// pb_port_arbiter: two-master port-bus arbiter, CPU always wins, master 1 fills idle slots
module pb_port_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] cpu_addr_i,
  input  logic [7:0] cpu_data_i,
  input  logic       cpu_rd_i,
  input  logic       cpu_wr_i,
  output logic [7:0] cpu_data_o,
  input  logic       m1_req_i,
  input  logic       m1_we_i,
  input  logic [7:0] m1_addr_i,
  input  logic [7:0] m1_wdata_i,
  output logic       m1_ack_o,
  output logic       m1_err_o,
  output logic [7:0] m1_rdata_o,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_data_o,
  output logic       bus_rd_o,
  output logic       bus_wr_o,
  input  logic [7:0] bus_data_i,
  output logic       m1_busy_o
);
  typedef enum logic [2:0] {IDLE, REQ, RDATA, DONE, ERR, WAIT_DROP} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic cpu_sel, m1_issue;
  assign cpu_sel    = cpu_rd_i | cpu_wr_i;
  assign m1_issue   = !cpu_sel && state == REQ && m1_req_i;
  assign cpu_data_o = bus_data_i;
  assign bus_addr_o = m1_issue ? m1_addr_i : cpu_addr_i;
  assign bus_data_o = m1_issue ? m1_wdata_i : cpu_data_i;
  assign bus_wr_o   = cpu_sel ? cpu_wr_i : m1_issue & m1_we_i;
  assign bus_rd_o   = cpu_sel ? cpu_rd_i : m1_issue & !m1_we_i;
  assign m1_ack_o   = state == DONE || state == ERR;
  assign m1_err_o   = state == ERR;
  assign m1_busy_o  = state != IDLE;
  // State, wait counter and captured read data
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      cnt        <= '0;
      m1_rdata_o <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == RDATA) m1_rdata_o <= bus_data_i;
    end
  end
  // Next state: issue master 1 only on strobe-free cycles, abort on timeout
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (m1_req_i) begin
        state_nxt = REQ;
        cnt_nxt   = '0;
      end
      REQ: if (!m1_req_i) state_nxt = IDLE;
        else if (!cpu_sel) state_nxt = m1_we_i ? DONE : RDATA;
        else begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
          if (cnt_nxt >= CNT_W'(TIMEOUT)) state_nxt = ERR;
        end
      RDATA:     state_nxt = DONE;
      DONE:      state_nxt = WAIT_DROP;
      ERR:       state_nxt = WAIT_DROP;
      WAIT_DROP: if (!m1_req_i) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_pb_port_arbiter.sv
// tb_pb_port_arbiter: directed scenario tests for the port-bus arbiter
module tb_pb_port_arbiter;
  logic clk = 0, rst = 0;
  logic [7:0] cpu_addr = 0, cpu_data = 0, cpu_din, m1_addr = 0, m1_wdata = 0, m1_rdata;
  logic cpu_rd = 0, cpu_wr = 0, m1_req = 0, m1_we = 0, m1_ack, m1_err, m1_busy;
  logic [7:0] bus_addr, bus_dout, bus_din = 0;
  logic bus_rd, bus_wr;
  int checks = 0, failures = 0;

  pb_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_data),
    .cpu_rd_i(cpu_rd), .cpu_wr_i(cpu_wr), .cpu_data_o(cpu_din),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .bus_addr_o(bus_addr), .bus_data_o(bus_dout), .bus_rd_o(bus_rd), .bus_wr_o(bus_wr),
    .bus_data_i(bus_din), .m1_busy_o(m1_busy)
  );

  always #5 clk = ~clk;

  // Register file read port: registered, fixed contents
  always @(posedge clk)
    if (bus_rd)
      bus_din <= (bus_addr == 8'h20) ? 8'h3C : (bus_addr == 8'h21) ? 8'hC3 :
                 (bus_addr == 8'h30) ? 8'h5A : 8'h00;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset;
    rst = 0;
    tick();
    chk("rst_ack", {7'b0, m1_ack}, 8'h00);
    chk("rst_err", {7'b0, m1_err}, 8'h00);
    chk("rst_busy", {7'b0, m1_busy}, 8'h00);
    chk("rst_rdata", m1_rdata, 8'h00);
    chk("rst_strobes", {6'b0, bus_rd, bus_wr}, 8'h00);
    rst = 1;
    tick();
  endtask

  task automatic test_write;
    m1_req = 1; m1_we = 1; m1_addr = 8'h10; m1_wdata = 8'hA5;
    #1;
    chk("wr_c0_strobes", {6'b0, bus_rd, bus_wr}, 8'h00);
    tick();
    chk("wr_c1_strobes", {6'b0, bus_rd, bus_wr}, 8'h01);
    chk("wr_c1_addr", bus_addr, 8'h10);
    chk("wr_c1_data", bus_dout, 8'hA5);
    chk("wr_c1_ack", {7'b0, m1_ack}, 8'h00);
    tick();
    chk("wr_c2_strobes", {6'b0, bus_rd, bus_wr}, 8'h00);
    chk("wr_c2_ack_err", {6'b0, m1_ack, m1_err}, 8'h02);
    tick();
    chk("wr_c3_ack_held_req", {6'b0, m1_ack, bus_wr}, 8'h00);
    m1_req = 0;
    tick();
    tick();
    chk("wr_idle_busy", {7'b0, m1_busy}, 8'h00);
  endtask

  task automatic test_read;
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    tick();
    chk("rd_c1_strobes", {6'b0, bus_rd, bus_wr}, 8'h02);
    chk("rd_c1_addr", bus_addr, 8'h20);
    tick();
    chk("rd_c2_strobes_ack", {5'b0, bus_rd, bus_wr, m1_ack}, 8'h00);
    tick();
    chk("rd_c3_ack_err", {6'b0, m1_ack, m1_err}, 8'h02);
    chk("rd_c3_rdata", m1_rdata, 8'h3C);
    m1_req = 0;
    tick();
    tick();
  endtask

  task automatic test_collision;
    m1_req = 1; m1_we = 1; m1_addr = 8'h40; m1_wdata = 8'h11;
    tick();
    cpu_wr = 1; cpu_addr = 8'h05; cpu_data = 8'h77;
    #1;
    chk("col_cpu_addr", bus_addr, 8'h05);
    chk("col_cpu_data", bus_dout, 8'h77);
    chk("col_cpu_strobes", {6'b0, bus_rd, bus_wr}, 8'h01);
    tick();
    cpu_wr = 0;
    #1;
    chk("col_m1_addr", bus_addr, 8'h40);
    chk("col_m1_data", bus_dout, 8'h11);
    chk("col_m1_strobes_ack", {5'b0, bus_rd, bus_wr, m1_ack}, 8'h02);
    tick();
    chk("col_ack_err", {6'b0, m1_ack, m1_err}, 8'h02);
    m1_req = 0;
    tick();
    tick();
  endtask

  task automatic test_timeout;
    m1_req = 1; m1_we = 0; m1_addr = 8'h50;
    tick();
    cpu_wr = 1; cpu_addr = 8'h60; cpu_data = 8'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait_addr", bus_addr, 8'h60);
      chk("to_wait_ack", {7'b0, m1_ack}, 8'h00);
      tick();
    end
    chk("to_ack_err", {6'b0, m1_ack, m1_err}, 8'h03);
    chk("to_rdata_kept", m1_rdata, 8'h3C);
    chk("to_bus_cpu", {bus_rd, bus_wr, bus_dout[5:0]}, {2'b01, 6'h19});
    tick();
    chk("to_ack_done", {6'b0, m1_ack, m1_err}, 8'h00);
    cpu_wr = 0; m1_req = 0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back;
    m1_req = 1; m1_we = 0; m1_addr = 8'h21;
    tick();
    chk("b2b_m1_rd", {bus_rd, bus_addr[6:0]}, {1'b1, 7'h21});
    tick();
    cpu_rd = 1; cpu_addr = 8'h30;
    #1;
    chk("b2b_cpu_addr", bus_addr, 8'h30);
    chk("b2b_cpu_rd", {6'b0, bus_rd, bus_wr}, 8'h02);
    chk("b2b_prev_data", cpu_din, 8'hC3);
    tick();
    cpu_rd = 0;
    #1;
    chk("b2b_ack", {7'b0, m1_ack}, 8'h01);
    chk("b2b_rdata", m1_rdata, 8'hC3);
    chk("b2b_cpu_data", cpu_din, 8'h5A);
    m1_req = 0;
    tick();
    tick();
  endtask

  task automatic test_abort;
    m1_req = 1; m1_we = 1; m1_addr = 8'h70; m1_wdata = 8'h33;
    tick();
    cpu_wr = 1; cpu_addr = 8'h01; cpu_data = 8'h02;
    #1;
    chk("ab_busy", {7'b0, m1_busy}, 8'h01);
    tick();
    cpu_wr = 0; m1_req = 0;
    #1;
    chk("ab_no_issue", {6'b0, bus_rd, bus_wr}, 8'h00);
    tick();
    chk("ab_idle", {6'b0, m1_busy, m1_ack}, 8'h00);
    tick();
    chk("ab_no_ack", {6'b0, m1_busy, m1_ack}, 8'h00);
  endtask

  task automatic test_reset_mid;
    m1_req = 1; m1_we = 0; m1_addr = 8'h20;
    tick();
    tick();
    rst = 0;
    #1;
    chk("rm_busy_ack", {6'b0, m1_busy, m1_ack}, 8'h00);
    chk("rm_rdata", m1_rdata, 8'h00);
    chk("rm_strobes", {6'b0, bus_rd, bus_wr}, 8'h00);
    m1_req = 0;
    tick();
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rm_post_release", {5'b0, bus_rd, bus_wr, m1_busy}, 8'h00);
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_write();
    test_read();
    test_collision();
    test_timeout();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pb_port_arbiter.md
Name: pb_port_arbiter

Overview:
Two-master arbiter for the 8-bit PicoBlaze port bus that feeds the SoC register file.
- Master 0 is the KCPSM3 CPU. It cannot be stalled, so it always wins and passes through with zero added latency.
- Master 1 is a secondary requester, such as a UART debug bridge or DMA sequencer. It uses a req/ack handshake and is slotted into cycles where the CPU has no strobe.
- The block sits between the CPU, master 1 and pb_soc_registers, replacing the direct CPU-to-register-file connection.

Parameters:
TIMEOUT, 255, maximum number of cycles a master-1 request may wait for a free slot before it is aborted with an error.
CNT_W, 8, width of the wait counter; TIMEOUT must be less than 2**CNT_W.

Ports:
clk_i  input  1  system clock; every flop is on its rising edge.
rst_i  input  1  reset, asynchronous, active-low.
cpu_addr_i  input  8  CPU port_id.
cpu_data_i  input  8  CPU out_port.
cpu_rd_i  input  1  CPU read_strobe.
cpu_wr_i  input  1  CPU write_strobe.
cpu_data_o  output  8  CPU in_port; combinational copy of bus_data_i.
m1_req_i  input  1  master-1 request; held high until m1_ack_o.
m1_we_i  input  1  1 = write, 0 = read; stable while m1_req_i is high.
m1_addr_i  input  8  master-1 address; stable while m1_req_i is high.
m1_wdata_i  input  8  master-1 write data; stable while m1_req_i is high.
m1_ack_o  output  1  one-cycle completion pulse.
m1_err_o  output  1  asserted together with m1_ack_o when the request timed out.
m1_rdata_o  output  8  read data; valid from m1_ack_o until the next ack.
bus_addr_o  output  8  to register file addr_i.
bus_data_o  output  8  to register file data_i.
bus_rd_o  output  1  to register file rd_i.
bus_wr_o  output  1  to register file wr_i.
bus_data_i  input  8  from register file data_o; registered there, so valid 1 cycle after bus_rd_o.
m1_busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_i low, asynchronous) forces:
  - state to IDLE and the wait counter to 0;
  - m1_ack_o, m1_err_o and m1_busy_o to 0;
  - m1_rdata_o to 8'h00.
- Bus outputs are combinational with no latency:
  - cpu_sel = cpu_rd_i | cpu_wr_i.
  - If cpu_sel is high, bus_* = cpu_*.
  - Else, if the state is REQ and m1_req_i is high, bus_addr_o = m1_addr_i and bus_data_o = m1_wdata_i, with bus_wr_o = m1_we_i and bus_rd_o = !m1_we_i.
  - Otherwise bus_rd_o = bus_wr_o = 0, and bus_addr_o/bus_data_o carry the CPU values.
- bus_rd_o and bus_wr_o are never both high.
- States:
  - IDLE:
    - If m1_req_i is high, go to REQ with the counter cleared.
    - A request seen in IDLE is never issued in that same cycle, so the minimum latency is 1 cycle to issue.
  - REQ:
    - If cpu_sel is low, master 1 is issued this cycle: a write goes to DONE, a read goes to RDATA.
    - If cpu_sel is high, increment the counter. When the counter reaches TIMEOUT, go to ERR without issuing.
  - RDATA:
    - Capture bus_data_i into m1_rdata_o and go to DONE.
    - A CPU strobe in this cycle is legal and does not disturb the capture, because the register file returns the previous cycle's read.
  - DONE: pulse m1_ack_o = 1 and go to WAIT_DROP.
  - ERR: pulse m1_ack_o = 1 and m1_err_o = 1; m1_rdata_o is unchanged; go to WAIT_DROP.
  - WAIT_DROP: wait for m1_req_i to go low, then go to IDLE. This prevents double issue from a requester that holds req high.
- Completion latency, measured from the first req-high cycle in IDLE to the ack cycle with no CPU strobes:
  - write: 2 cycles;
  - read: 3 cycles.
- If m1_req_i drops in REQ before issue, the request is abandoned: return to IDLE with no ack.
- The CPU is never delayed, blocked or given altered data under any condition.
- The counter saturates and is cleared on entry to REQ.

Test Plan:
- Master-1 write, CPU idle: m1_req=1, we=1, addr=8'h10, wdata=8'hA5 → bus_wr_o=1 with addr 8'h10 and data 8'hA5 for exactly 1 cycle; m1_ack_o pulses 2 cycles after req; m1_err_o=0.
- Master-1 read, CPU idle: register file returns 8'h3C for addr 8'h20 → bus_rd_o for 1 cycle; m1_rdata_o=8'h3C at ack, 3 cycles after req.
- Collision:
  - Stimulus: CPU write addr 8'h05, data 8'h77 in the same cycle master 1 is in REQ.
  - Bus must carry the CPU transaction unchanged.
  - Master 1 must issue on the next strobe-free cycle.
  - The wait counter must reach 1.
- Timeout: TIMEOUT=4, CPU strobes held continuously → no master-1 strobe ever appears; ack and err both pulse after 4 wait cycles; m1_rdata_o keeps its old value.
- Back-to-back reads: master-1 read issued with a CPU read in the next cycle → m1_rdata_o captures master 1's data; CPU sees its own data one cycle later.
- Abort and reset:
  - Dropping req in REQ → IDLE, no ack.
  - rst_i low mid-RDATA → all outputs at reset values immediately, with no strobe glitch after release.
